// File: rtl/pulse_pkg.sv
// rtl/pulse_pkg.sv - shared types, constants and helpers for the pulse-train generator
// Contents: pg_state_t FSM encoding, PG_CNT_W default counter width,
//           clamp_dur() which turns a zero duration into one cycle.
package pulse_pkg;

  localparam int PG_CNT_W = 32;
  // Durations pass through clamp_dur zero-extended to this width, so any
  // CNT_W up to 64 can share the one helper.
  localparam int DUR_W = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2,
    HOLD = 2'd3
  } pg_state_t;

  function automatic logic [DUR_W-1:0] clamp_dur(input logic [DUR_W-1:0] d);
    return (d == '0) ? DUR_W'(1) : d;
  endfunction

endpackage

// File: rtl/pulse_timer.sv
// rtl/pulse_timer.sv - loadable down-counter timing one FSM interval
// Ports: clk, rst (sync, active-high)
//        load/value : restart the interval with value cycles (value >= 1)
//        count      : cycles remaining in the current interval, this one included
//        expire     : high on the last cycle of the interval
module pulse_timer
  import pulse_pkg::*;
#(
  parameter int CNT_W = PG_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] value,
  output logic [CNT_W-1:0] count,
  output logic             expire
);

  // Holding at 1 after expiry keeps the counter from wrapping while the
  // FSM sits in IDLE; every running interval is reloaded on expire.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (count > CNT_W'(1)) begin
      count <= count - CNT_W'(1);
    end
  end

  assign expire = (count == CNT_W'(1));

endmodule

// File: rtl/multi_pulse_gen.sv
// rtl/multi_pulse_gen.sv - programmable gate pulse train with optional complementary drive
// Ports: clk, rst (sync, active-high)
//        trig (rising edge starts a train), enable (gates pulses 2..N),
//        abort (stop a running train, holdoff still applies)
//        n_pulses, t_first, t_high, t_low, t_hold : train setup, latched at start
//        k1 high-side gate, k2 low-side gate, busy, done (normal-end strobe)
module multi_pulse_gen
  import pulse_pkg::*;
#(
  parameter int CNT_W      = PG_CNT_W,
  parameter int MAX_PULSES = 4,
  parameter int COMPL      = 0,
  parameter int DEAD       = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            trig,
  input  logic                            enable,
  input  logic                            abort,
  input  logic [$clog2(MAX_PULSES+1)-1:0] n_pulses,
  input  logic [CNT_W-1:0]                t_first,
  input  logic [CNT_W-1:0]                t_high,
  input  logic [CNT_W-1:0]                t_low,
  input  logic [CNT_W-1:0]                t_hold,
  output logic                            k1,
  output logic                            k2,
  output logic                            busy,
  output logic                            done
);

  localparam int NP_W = $clog2(MAX_PULSES + 1);

  pg_state_t        state, state_n;
  logic             trig_q;
  logic [NP_W-1:0]  idx, idx_n;
  logic [NP_W-1:0]  n_lat, n_clamped;
  logic [CNT_W-1:0] hi_lat, lo_lat, hold_lat;
  logic             aborted, aborted_n;
  logic             latch;
  logic             k1_n, k2_n, done_n;
  logic             tmr_load;
  logic [CNT_W-1:0] tmr_val;
  logic [CNT_W-1:0] count;
  logic             expire;
  logic [CNT_W-1:0] cnt_next;
  logic             k2_window;

  pulse_timer #(.CNT_W(CNT_W)) u_timer (
    .clk   (clk),
    .rst   (rst),
    .load  (tmr_load),
    .value (tmr_val),
    .count (count),
    .expire(expire)
  );

  always_comb begin
    n_clamped = n_pulses;
    if (n_pulses == '0) begin
      n_clamped = NP_W'(1);
    end else if (n_pulses > NP_W'(MAX_PULSES)) begin
      n_clamped = NP_W'(MAX_PULSES);
    end
  end

  // k2 is registered, so the dead-time window is evaluated on the count the
  // gap will show next cycle: high while DEAD < count <= t_low - DEAD.
  assign cnt_next  = count - CNT_W'(1);
  assign k2_window = (COMPL != 0) &&
                     (cnt_next > CNT_W'(DEAD)) &&
                     (({1'b0, cnt_next} + (CNT_W+1)'(DEAD)) <= {1'b0, lo_lat});

  always_comb begin
    state_n   = state;
    idx_n     = idx;
    aborted_n = aborted;
    latch     = 1'b0;
    tmr_load  = 1'b0;
    tmr_val   = hold_lat;
    k1_n      = 1'b0;
    k2_n      = 1'b0;
    done_n    = 1'b0;
    case (state)
      IDLE: begin
        if (trig && !trig_q) begin
          state_n   = HIGH;
          idx_n     = '0;
          aborted_n = 1'b0;
          latch     = 1'b1;
          tmr_load  = 1'b1;
          tmr_val   = CNT_W'(clamp_dur(DUR_W'(t_first)));
          k1_n      = 1'b1;
        end
      end
      HIGH: begin
        if (abort) begin
          state_n   = HOLD;
          aborted_n = 1'b1;
          tmr_load  = 1'b1;
          tmr_val   = hold_lat;
        end else if (expire) begin
          tmr_load = 1'b1;
          if ((idx + NP_W'(1)) < n_lat) begin
            state_n = LOW;
            tmr_val = lo_lat;
          end else begin
            state_n = HOLD;
            tmr_val = hold_lat;
          end
        end else begin
          k1_n = (idx == '0) ? 1'b1 : enable;
        end
      end
      LOW: begin
        if (abort) begin
          state_n   = HOLD;
          aborted_n = 1'b1;
          tmr_load  = 1'b1;
          tmr_val   = hold_lat;
        end else if (expire) begin
          state_n  = HIGH;
          idx_n    = idx + NP_W'(1);
          tmr_load = 1'b1;
          tmr_val  = hi_lat;
          k1_n     = enable;
        end else begin
          k2_n = k2_window;
        end
      end
      HOLD: begin
        if (expire) begin
          state_n = IDLE;
          done_n  = !aborted;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      trig_q   <= 1'b1;
      idx      <= '0;
      aborted  <= 1'b0;
      n_lat    <= NP_W'(1);
      hi_lat   <= CNT_W'(1);
      lo_lat   <= CNT_W'(1);
      hold_lat <= CNT_W'(1);
      k1       <= 1'b0;
      k2       <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state   <= state_n;
      trig_q  <= trig;
      idx     <= idx_n;
      aborted <= aborted_n;
      if (latch) begin
        n_lat    <= n_clamped;
        hi_lat   <= CNT_W'(clamp_dur(DUR_W'(t_high)));
        lo_lat   <= CNT_W'(clamp_dur(DUR_W'(t_low)));
        hold_lat <= CNT_W'(clamp_dur(DUR_W'(t_hold)));
      end
      k1   <= k1_n;
      k2   <= k2_n;
      busy <= (state_n != IDLE);
      done <= done_n;
    end
  end

endmodule
